// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generator + fetch buffer.
// Drives a combinational instruction cache, buffers {pc, instr} pairs in a
// small FIFO and hands them to decode over valid/ready. Redirects from
// execute flush the buffer; misaligned targets park the stage in FAULT.
module instruction_fetch #(
  parameter int unsigned          ADDR_WID   = 64,
  parameter int unsigned          INSTR_WID  = 32,
  parameter logic [ADDR_WID-1:0]  RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_en_i,
  output logic [ADDR_WID-1:0]  icache_addr_o,
  input  logic [INSTR_WID-1:0] icache_instr_i,
  input  logic                 redirect_i,
  input  logic [ADDR_WID-1:0]  redirect_pc_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [INSTR_WID-1:0] instr_o,
  output logic [ADDR_WID-1:0]  pc_o,
  output logic                 fault_o,
  output logic [ADDR_WID-1:0]  fault_pc_o
);

  localparam int unsigned STEP  = INSTR_WID / 8;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_WID-1:0] PC_STEP    = ADDR_WID'(STEP);
  localparam logic [ADDR_WID-1:0] ALIGN_MASK = ADDR_WID'(STEP - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                                 r_state;
  state_t                                 w_state_nxt;
  logic [ADDR_WID-1:0]                    r_pc;
  logic [FIFO_DEPTH-1:0][ADDR_WID-1:0]    r_pc_mem;
  logic [FIFO_DEPTH-1:0][INSTR_WID-1:0]   r_ins_mem;
  logic [PTR_W-1:0]                       r_wr_ptr;
  logic [PTR_W-1:0]                       r_rd_ptr;
  logic [CNT_W-1:0]                       r_count;
  logic                                   r_fault;
  logic [ADDR_WID-1:0]                    r_fault_pc;

  logic w_misaligned;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_pop;
  logic w_push;

  // Redirect classification: any low address bits below the instruction size
  // make the target unfetchable.
  always_comb begin
    w_misaligned = |(redirect_pc_i & ALIGN_MASK);
    w_redir_ok   = redirect_i & ~w_misaligned;
    w_redir_bad  = redirect_i &  w_misaligned;
  end

  // Handshake: a full buffer can still take a word in a cycle where decode
  // drains one; a redirect cycle never pushes (its word is on the wrong path).
  always_comb begin
    w_pop  = (r_count != '0) & instr_ready_i;
    w_push = (r_state == S_RUN) & ~redirect_i & ((r_count < CNT_FULL) | w_pop);
  end

  // Next-state logic; redirects take priority over the enable-driven moves.
  always_comb begin
    w_state_nxt = r_state;
    if (w_redir_bad) begin
      w_state_nxt = S_FAULT;
    end else if (w_redir_ok) begin
      w_state_nxt = fetch_en_i ? S_RUN : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (fetch_en_i)  w_state_nxt = S_RUN;
        S_RUN:   if (!fetch_en_i) w_state_nxt = S_IDLE;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // PC: load aligned redirect target, otherwise step past each pushed word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          r_pc <= RESET_PC;
    else if (w_redir_ok) r_pc <= redirect_pc_i;
    else if (w_push)     r_pc <= r_pc + PC_STEP;
  end

  // FIFO pointers and occupancy; any redirect empties the buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc_mem  <= '0;
      r_ins_mem <= '0;
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_pc;
      r_ins_mem[r_wr_ptr] <= icache_instr_i;
    end
  end

  // Sticky misalignment fault; only an aligned redirect clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_redir_bad) begin
      r_fault    <= 1'b1;
      r_fault_pc <= redirect_pc_i;
    end else if (w_redir_ok) begin
      r_fault    <= 1'b0;
    end
  end

  assign icache_addr_o = r_pc;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_ins_mem[r_rd_ptr];
  assign pc_o          = r_pc_mem[r_rd_ptr];
  assign fault_o       = r_fault;
  assign fault_pc_o    = r_fault_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic checked
// against a queue-based model of the fetch stream.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, ready, redir;
  logic [63:0] rpc;
  logic [63:0] addr, pc_o, fpc;
  logic [31:0] instr, ins_o;
  logic        valid, fault;

  logic        en2, ready2, redir2;
  logic [63:0] rpc2, addr2, pc2, fpc2;
  logic [31:0] instr2, ins2;
  logic        valid2, fault2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Cache contents: word at byte address a is 0x100 + a/4.
  function automatic logic [31:0] cword(input logic [63:0] a);
    return 32'h100 + a[33:2];
  endfunction

  assign instr  = cword(addr);
  assign instr2 = cword(addr2);

  instruction_fetch dut (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(en), .icache_addr_o(addr),
    .icache_instr_i(instr), .redirect_i(redir), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(ins_o),
    .pc_o(pc_o), .fault_o(fault), .fault_pc_o(fpc)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(en2), .icache_addr_o(addr2),
    .icache_instr_i(instr2), .redirect_i(redir2), .redirect_pc_i(rpc2),
    .instr_valid_o(valid2), .instr_ready_i(ready2), .instr_o(ins2),
    .pc_o(pc2), .fault_o(fault2), .fault_pc_o(fpc2)
  );

  // Reference model: the stream of fetched words as a queue.
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc, m_fpc;
  bit          m_fault;
  int          m_mode; // 0 stopped, 1 fetching, 2 faulted

  task automatic model_reset();
    mq.delete();
    m_pc = 64'd0; m_fpc = 64'd0; m_fault = 0; m_mode = 0;
  endtask

  task automatic model_step();
    bit   pop, push;
    ent_t e;
    pop = (mq.size() != 0) && ready;
    if (redir) begin
      mq.delete();
      if (rpc[1:0] != 2'b00) begin
        m_mode = 2; m_fault = 1; m_fpc = rpc;
      end else begin
        m_pc = rpc; m_fault = 0; m_mode = en ? 1 : 0;
      end
    end else begin
      push = (m_mode == 1) && (mq.size() < 4 || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = m_pc; e.ins = cword(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
      end
      if (m_mode == 0 && en) m_mode = 1;
      else if (m_mode == 1 && !en) m_mode = 0;
    end
  endtask

  // One clock: advance the model with the current inputs, then land on negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 0; ready = 0; redir = 0; rpc = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 0; ready = 0; redir = 0; rpc = '0;
    en2 = 0; ready2 = 0; redir2 = 0; rpc2 = '0;
    model_reset();
    @(negedge clk);
    n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_chk++; if (ins_o !== 32'd0) $display("FAIL reset_instr got %h want 0", ins_o); else n_pass++;
    n_chk++; if (pc_o !== 64'd0) $display("FAIL reset_pc got %h want 0", pc_o); else n_pass++;
    n_chk++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
    n_chk++; if (fpc !== 64'd0) $display("FAIL reset_fault_pc got %h want 0", fpc); else n_pass++;
    n_chk++; if (addr !== 64'd0) $display("FAIL reset_addr got %h want 0", addr); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    en = 1; ready = 1;
    for (int t = 0; t < 10 && !valid; t++) tick();
    n_chk++; if (valid !== 1'b1) $display("FAIL stream_first_valid got %b want 1", valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (valid !== 1'b1 || pc_o !== 64'(4*k) || ins_o !== 32'(32'h100 + k))
        $display("FAIL stream_%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 k, valid, pc_o, ins_o, 64'(4*k), 32'(32'h100 + k));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1; ready = 0;
    for (int t = 0; t < 8; t++) tick();
    n_chk++; if (addr !== 64'd16) $display("FAIL bp_addr_frozen got %h want 10", addr); else n_pass++;
    tick();
    n_chk++; if (addr !== 64'd16) $display("FAIL bp_addr_hold got %h want 10", addr); else n_pass++;
    ready = 1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (valid !== 1'b1 || pc_o !== 64'(4*k))
        $display("FAIL bp_drain_%0d got v=%b pc=%h want v=1 pc=%h", k, valid, pc_o, 64'(4*k));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1; ready = 0;
    for (int t = 0; t < 10 && mq.size() != 3; t++) tick();
    n_chk++; if (valid !== 1'b1) $display("FAIL redir_pre_valid got %b want 1", valid); else n_pass++;
    redir = 1; rpc = 64'h40;
    tick();
    redir = 0;
    n_chk++; if (valid !== 1'b0) $display("FAIL redir_flush got %b want 0", valid); else n_pass++;
    ready = 1;
    tick();
    n_chk++;
    if (valid !== 1'b1 || pc_o !== 64'h40 || ins_o !== 32'h110)
      $display("FAIL redir_target got v=%b pc=%h ins=%h want v=1 pc=40 ins=110", valid, pc_o, ins_o);
    else n_pass++;
    tick();
    n_chk++; if (pc_o !== 64'h44) $display("FAIL redir_next got %h want 44", pc_o); else n_pass++;
  endtask

  task automatic test_fault();
    redir = 1; rpc = 64'h42;
    tick();
    redir = 0;
    n_chk++;
    if (fault !== 1'b1 || fpc !== 64'h42 || valid !== 1'b0)
      $display("FAIL fault_set got f=%b fpc=%h v=%b want f=1 fpc=42 v=0", fault, fpc, valid);
    else n_pass++;
    for (int t = 0; t < 3; t++) tick();
    n_chk++;
    if (valid !== 1'b0 || addr !== m_pc || fault !== 1'b1)
      $display("FAIL fault_idle got v=%b addr=%h f=%b want v=0 addr=%h f=1", valid, addr, fault, m_pc);
    else n_pass++;
    redir = 1; rpc = 64'h80;
    tick();
    redir = 0;
    n_chk++;
    if (fault !== 1'b0 || addr !== 64'h80)
      $display("FAIL fault_clear got f=%b addr=%h want f=0 addr=80", fault, addr);
    else n_pass++;
    tick();
    n_chk++;
    if (valid !== 1'b1 || pc_o !== 64'h80)
      $display("FAIL fault_resume got v=%b pc=%h want v=1 pc=80", valid, pc_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    en2 = 1; ready2 = 1;
    for (int t = 0; t < 10 && !valid2; t++) tick();
    n_chk++; if (pc2 !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wrap_0 got %h want fffffffffffffff8", pc2); else n_pass++;
    tick();
    n_chk++; if (pc2 !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_1 got %h want fffffffffffffffc", pc2); else n_pass++;
    tick();
    n_chk++;
    if (valid2 !== 1'b1 || pc2 !== 64'd0) $display("FAIL wrap_2 got v=%b pc=%h want v=1 pc=0", valid2, pc2);
    else n_pass++;
    en2 = 0; ready2 = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1; ready = 0;
    for (int t = 0; t < 8; t++) tick();
    n_chk++; if (valid !== 1'b1) $display("FAIL rstmid_full_valid got %b want 1", valid); else n_pass++;
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (valid !== 1'b0 || pc_o !== 64'd0 || addr !== 64'd0)
      $display("FAIL rstmid_clear got v=%b pc=%h addr=%h want 0 0 0", valid, pc_o, addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ready = 1;
    for (int t = 0; t < 10 && !valid; t++) tick();
    n_chk++;
    if (valid !== 1'b1 || pc_o !== 64'd0 || ins_o !== 32'h100)
      $display("FAIL rstmid_restart got v=%b pc=%h ins=%h want v=1 pc=0 ins=100", valid, pc_o, ins_o);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom % 8) != 0;
      ready = ($urandom % 3) != 0;
      redir = ($urandom % 16) == 0;
      rpc   = (64'($urandom_range(0, 255)) << 2) |
              (($urandom % 4 == 0) ? 64'($urandom % 4) : 64'd0);
      tick();
      ev = (mq.size() != 0);
      n_chk++; if (valid !== ev) $display("FAIL rnd_valid c=%0d got %b want %b", c, valid, ev); else n_pass++;
      if (ev) begin
        n_chk++;
        if (pc_o !== mq[0].pc || ins_o !== mq[0].ins)
          $display("FAIL rnd_head c=%0d got pc=%h ins=%h want pc=%h ins=%h", c, pc_o, ins_o, mq[0].pc, mq[0].ins);
        else n_pass++;
      end
      n_chk++; if (addr !== m_pc) $display("FAIL rnd_addr c=%0d got %h want %h", c, addr, m_pc); else n_pass++;
      n_chk++;
      if (fault !== m_fault || fpc !== m_fpc)
        $display("FAIL rnd_fault c=%0d got f=%b fpc=%h want f=%b fpc=%h", c, fault, fpc, m_fault, m_fpc);
      else n_pass++;
    end
    redir = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
